// File: rtl/rcswitch_pkg.sv
// Shared constants, state encoding and frame builder for the rcswitch send/receive pair.
// Frame layout is {addr, chan, stat, sync}, transmitted MSB first.
package rcswitch_pkg;

  localparam int ADDR_W  = 40;
  localparam int CHAN_W  = 40;
  localparam int STAT_W  = 16;
  localparam int SYNC_W  = 32;
  localparam int FRAME_W = 128;

  localparam logic [SYNC_W-1:0] SYNC_WORD = 32'h8000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TX   = 1'b1
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [ADDR_W-1:0] a,
    input logic [CHAN_W-1:0] c,
    input logic [STAT_W-1:0] s
  );
    return {a, c, s, SYNC_WORD};
  endfunction

endpackage

// File: rtl/rcswitch_tick.sv
// Symbol-period counter: o_tc strobes for one cycle every PULSE_CYCLES clocks, zero latency.
// Held at zero while i_clr is high; no backpressure.
module rcswitch_tick #(
  parameter int PULSE_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tc
);

  localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PULSE_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/rcswitch_send.sv
// Serialises one addr/chan/stat frame REPEAT times, PULSE_CYCLES clocks per bit; first bit one cycle after accept.
// send is only taken while ready=1; requests during a transmission are dropped, not queued.
module rcswitch_send
  import rcswitch_pkg::*;
#(
  parameter int PULSE_CYCLES = 5,
  parameter int REPEAT       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CHAN_W-1:0] chan,
  input  logic [STAT_W-1:0] stat,
  input  logic              send,
  output logic              out,
  output logic              ready
);

  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);
  localparam logic [6:0]    BIT_LAST = 7'(FRAME_W - 1);

  state_t             r_state;
  logic [FRAME_W-1:0] r_frame;
  logic [6:0]         r_bit;
  logic [RW-1:0]      r_rep;
  logic               r_out;
  logic               r_ready;

  logic               w_clr;
  logic               w_tc;
  logic [FRAME_W-1:0] w_frame;

  assign w_clr   = (r_state == ST_IDLE);
  assign w_frame = build_frame(addr, chan, stat);

  rcswitch_tick #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_clr),
    .o_tc (w_tc)
  );

  // The frame register rotates rather than shifts, so after 128 steps it holds the
  // original frame again and a repeat needs no reload; out always mirrors r_frame[MSB].
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_frame <= '0;
      r_bit   <= '0;
      r_rep   <= '0;
      r_out   <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (send) begin
            r_frame <= w_frame;
            r_out   <= w_frame[FRAME_W-1];
            r_ready <= 1'b0;
            r_bit   <= '0;
            r_rep   <= '0;
            r_state <= ST_TX;
          end
        end
        ST_TX: begin
          if (w_tc) begin
            if (r_bit == BIT_LAST && r_rep == REP_LAST) begin
              r_out   <= 1'b0;
              r_ready <= 1'b1;
              r_bit   <= '0;
              r_rep   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_frame <= {r_frame[FRAME_W-2:0], r_frame[FRAME_W-1]};
              r_out   <= r_frame[FRAME_W-2];
              if (r_bit == BIT_LAST) begin
                r_bit <= '0;
                r_rep <= r_rep + RW'(1);
              end else begin
                r_bit <= r_bit + 7'd1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out   = r_out;
  assign ready = r_ready;

endmodule
